// File: rtl/led_pattern_ctrl_if.sv
// LED pattern engine bus: mode select in, LED drive and status out.
interface led_pattern_ctrl_if #(
    parameter int LED_NUM = 4
);
    logic [2:0]         cntl;
    logic [LED_NUM-1:0] led;
    logic [2:0]         cur_mode;
    logic               step_tick;

    // Command side: drives the mode select, observes the LEDs and status.
    modport master (
        output cntl,
        input  led,
        input  cur_mode,
        input  step_tick
    );

    // Pattern engine side.
    modport slave (
        input  cntl,
        output led,
        output cur_mode,
        output step_tick
    );
endinterface

// File: rtl/led_pattern_ctrl.sv
// LED pattern engine: off / flash / run / bounce / breath / all-on patterns
// built from one shared step timer and one PWM generator. Every output is
// decoded from registered state only; a mode change restarts the pattern.
module led_pattern_ctrl #(
    parameter int LED_NUM        = 4,
    parameter int TICK_DIV       = 25_000_000,
    parameter int PWM_BITS       = 8,
    parameter int BREATH_PERIODS = 100
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    led_pattern_ctrl_if.slave bus
);
    localparam int POS_W = (LED_NUM > 1) ? $clog2(LED_NUM) : 1;
    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int BRC_W = (BREATH_PERIODS > 1) ? $clog2(BREATH_PERIODS) : 1;

    localparam logic [TICK_W-1:0]   TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [POS_W-1:0]    POS_LAST  = POS_W'(LED_NUM - 1);
    localparam logic [PWM_BITS-1:0] DUTY_MAX  = '1;
    localparam logic [BRC_W-1:0]    BRC_LAST  = BRC_W'(BREATH_PERIODS - 1);
    localparam logic [LED_NUM-1:0]  LED_ONE   = LED_NUM'(1);

    localparam logic [2:0] MODE_OFF    = 3'd0;
    localparam logic [2:0] MODE_FLASH  = 3'd1;
    localparam logic [2:0] MODE_RUN    = 3'd2;
    localparam logic [2:0] MODE_BREATH = 3'd3;
    localparam logic [2:0] MODE_BOUNCE = 3'd4;
    localparam logic [2:0] MODE_ALLON  = 3'd5;

    // Direction encoding shared by the bounce position and the breath duty.
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    logic [2:0]          r_mode;
    logic [TICK_W-1:0]   r_tick_cnt;
    logic                r_phase;
    logic [POS_W-1:0]    r_pos;
    logic                r_dir;
    logic [PWM_BITS-1:0] r_duty;
    logic                r_dir_b;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [BRC_W-1:0]    r_breath_cnt;

    logic                w_step;
    logic                w_pwm_on;
    logic [LED_NUM-1:0]  w_led;

    assign w_step   = (r_tick_cnt == TICK_LAST);
    assign w_pwm_on = (r_pwm_cnt < r_duty);

    // Mode capture, step timer and per-pattern state; only the active pattern advances.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode       <= MODE_OFF;
            r_tick_cnt   <= '0;
            r_phase      <= 1'b0;
            r_pos        <= '0;
            r_dir        <= DIR_UP;
            r_duty       <= '0;
            r_dir_b      <= DIR_UP;
            r_pwm_cnt    <= '0;
            r_breath_cnt <= '0;
        end else if (bus.cntl != r_mode) begin
            // New mode: restart everything, flash starts lit, no advance this edge.
            r_mode       <= bus.cntl;
            r_tick_cnt   <= '0;
            r_phase      <= 1'b1;
            r_pos        <= '0;
            r_dir        <= DIR_UP;
            r_duty       <= '0;
            r_dir_b      <= DIR_UP;
            r_pwm_cnt    <= '0;
            r_breath_cnt <= '0;
        end else begin
            r_tick_cnt <= w_step ? '0 : r_tick_cnt + 1'b1;
            case (r_mode)
                MODE_FLASH: begin
                    if (w_step) begin
                        r_phase <= ~r_phase;
                    end
                end
                MODE_RUN: begin
                    if (w_step) begin
                        r_pos <= (r_pos == POS_LAST) ? '0 : r_pos + 1'b1;
                    end
                end
                MODE_BOUNCE: begin
                    // A single LED has nowhere to bounce to, so pos stays at 0.
                    if (w_step && (LED_NUM > 1)) begin
                        if (r_dir == DIR_UP) begin
                            if (r_pos == POS_LAST) begin
                                r_dir <= DIR_DOWN;
                                r_pos <= r_pos - 1'b1;
                            end else begin
                                r_pos <= r_pos + 1'b1;
                            end
                        end else begin
                            if (r_pos == '0) begin
                                r_dir <= DIR_UP;
                                r_pos <= r_pos + 1'b1;
                            end else begin
                                r_pos <= r_pos - 1'b1;
                            end
                        end
                    end
                end
                MODE_BREATH: begin
                    r_pwm_cnt <= r_pwm_cnt + 1'b1;
                    // Duty only changes as pwm_cnt wraps, so each PWM period is clean.
                    if (r_pwm_cnt == DUTY_MAX) begin
                        if (r_breath_cnt == BRC_LAST) begin
                            r_breath_cnt <= '0;
                            if (r_dir_b == DIR_UP) begin
                                if (r_duty == DUTY_MAX) begin
                                    r_dir_b <= DIR_DOWN;
                                    r_duty  <= DUTY_MAX - 1'b1;
                                end else begin
                                    r_duty <= r_duty + 1'b1;
                                end
                            end else begin
                                if (r_duty == '0) begin
                                    r_dir_b <= DIR_UP;
                                    r_duty  <= {{(PWM_BITS-1){1'b0}}, 1'b1};
                                end else begin
                                    r_duty <= r_duty - 1'b1;
                                end
                            end
                        end else begin
                            r_breath_cnt <= r_breath_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // LED decode from registered state only; cntl never reaches led directly.
    always_comb begin
        w_led = '0;
        case (r_mode)
            MODE_FLASH:  w_led = {LED_NUM{r_phase}};
            MODE_RUN:    w_led = LED_ONE << r_pos;
            MODE_BOUNCE: w_led = LED_ONE << r_pos;
            MODE_BREATH: w_led = {LED_NUM{w_pwm_on}};
            MODE_ALLON:  w_led = '1;
            default:     w_led = '0;
        endcase
    end

    assign bus.led       = w_led;
    assign bus.cur_mode  = r_mode;
    assign bus.step_tick = w_step;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Testbench for led_pattern_ctrl: directed pattern scenarios plus randomized
// mode sequences checked against a closed-form reference model.
module tb_led_pattern_ctrl;
    localparam int N    = 4;
    localparam int TD   = 4;
    localparam int PB   = 3;
    localparam int BP   = 2;
    localparam int PER  = 1 << PB;
    localparam int MAXD = PER - 1;

    logic sys_clk = 1'b0;
    logic rst_n   = 1'b0;

    led_pattern_ctrl_if #(.LED_NUM(N)) bus ();

    led_pattern_ctrl #(
        .LED_NUM(N),
        .TICK_DIV(TD),
        .PWM_BITS(PB),
        .BREATH_PERIODS(BP)
    ) dut (
        .sys_clk(sys_clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 sys_clk = ~sys_clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: applied mode and number of edges since it was captured.
    logic [2:0] m_mode;
    int         m_t;
    logic [N-1:0] exp_led;
    logic         exp_tick;
    logic [2:0]   exp_mode;

    // Closed-form expected outputs from (mode, time since capture).
    function automatic void model_eval();
        int k, m, pos, pwm, p, q, duty;
        k = m_t / TD;
        exp_tick = ((m_t % TD) == TD - 1);
        exp_mode = m_mode;
        case (m_mode)
            3'd1: exp_led = ((k % 2) == 0) ? '1 : '0;
            3'd2: exp_led = N'(1 << (k % N));
            3'd4: begin
                m = k % (2 * N - 2);
                pos = (m < N) ? m : (2 * N - 2 - m);
                exp_led = N'(1 << pos);
            end
            3'd3: begin
                pwm  = m_t % PER;
                p    = m_t / (PER * BP);
                q    = p % (2 * MAXD);
                duty = (q <= MAXD) ? q : (2 * MAXD - q);
                exp_led = (pwm < duty) ? '1 : '0;
            end
            3'd5: exp_led = '1;
            default: exp_led = '0;
        endcase
    endfunction

    // Advance one clock: update the model with the sampled cntl, then settle.
    task automatic clk_edge();
        @(posedge sys_clk);
        if (rst_n) begin
            if (bus.cntl != m_mode) begin
                m_mode = bus.cntl;
                m_t = 0;
            end else begin
                m_t++;
            end
        end
        #1;
        model_eval();
    endtask

    task automatic test_reset();
        int edges;
        bit found;
        rst_n = 1'b0;
        bus.cntl = 3'd2;
        m_mode = 3'd0;
        m_t = 0;
        repeat (3) clk_edge();
        n_cmp++; if (bus.led !== 4'b0000) begin n_err++; $display("FAIL reset_led: got %b want %b", bus.led, 4'b0000); end
        n_cmp++; if (bus.cur_mode !== 3'd0) begin n_err++; $display("FAIL reset_mode: got %0d want 0", bus.cur_mode); end
        n_cmp++; if (bus.step_tick !== 1'b0) begin n_err++; $display("FAIL reset_tick: got %b want 0", bus.step_tick); end
        rst_n = 1'b1;
        clk_edge();
        n_cmp++; if (bus.cur_mode !== 3'd2) begin n_err++; $display("FAIL release_mode: got %0d want 2", bus.cur_mode); end
        n_cmp++; if (bus.led !== 4'b0001) begin n_err++; $display("FAIL release_led: got %b want 0001", bus.led); end
        edges = 1;
        found = 1'b0;
        while (!found && edges < 20) begin
            clk_edge();
            edges++;
            if (bus.step_tick === 1'b1) found = 1'b1;
        end
        n_cmp++; if (!found || edges != 4) begin n_err++; $display("FAIL first_tick: seen=%0d after %0d edges want after 4", found, edges); end
    endtask

    task automatic test_run();
        logic [3:0] seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        bus.cntl = 3'd0;
        clk_edge();
        bus.cntl = 3'd2;
        for (int c = 0; c < 20; c++) begin
            clk_edge();
            n_cmp++; if (bus.led !== seq[c / 4]) begin n_err++; $display("FAIL run_led c=%0d: got %b want %b", c, bus.led, seq[c / 4]); end
            n_cmp++; if (bus.step_tick !== ((c % 4) == 3)) begin n_err++; $display("FAIL run_tick c=%0d: got %b want %b", c, bus.step_tick, ((c % 4) == 3)); end
        end
    endtask

    task automatic test_bounce();
        logic [3:0] seq [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                4'b0100, 4'b0010, 4'b0001, 4'b0010};
        bus.cntl = 3'd4;
        for (int c = 0; c < 32; c++) begin
            clk_edge();
            n_cmp++; if (bus.led !== seq[c / 4]) begin n_err++; $display("FAIL bounce_led c=%0d: got %b want %b", c, bus.led, seq[c / 4]); end
        end
    endtask

    task automatic test_flash_allon();
        logic [3:0] want;
        bus.cntl = 3'd1;
        for (int c = 0; c < 14; c++) begin
            clk_edge();
            want = (((c / 4) % 2) == 0) ? 4'b1111 : 4'b0000;
            n_cmp++; if (bus.led !== want) begin n_err++; $display("FAIL flash_led c=%0d: got %b want %b", c, bus.led, want); end
        end
        bus.cntl = 3'd5;
        for (int c = 0; c < 8; c++) begin
            clk_edge();
            n_cmp++; if (bus.led !== 4'b1111) begin n_err++; $display("FAIL allon_led c=%0d: got %b want 1111", c, bus.led); end
        end
        n_cmp++; if (bus.cur_mode !== 3'd5) begin n_err++; $display("FAIL allon_mode: got %0d want 5", bus.cur_mode); end
    endtask

    task automatic test_breath();
        logic [3:0] want;
        bus.cntl = 3'd0;
        clk_edge();
        bus.cntl = 3'd3;
        for (int c = 0; c < 272; c++) begin
            clk_edge();
            n_cmp++; if (bus.led !== exp_led) begin n_err++; $display("FAIL breath_led c=%0d: got %b want %b", c, bus.led, exp_led); end
            if (c < 16) begin
                n_cmp++; if (bus.led !== 4'b0000) begin n_err++; $display("FAIL breath_dark c=%0d: got %b want 0000", c, bus.led); end
            end
            if (c >= 48 && c < 64) begin
                want = ((c % 8) < 3) ? 4'b1111 : 4'b0000;
                n_cmp++; if (bus.led !== want) begin n_err++; $display("FAIL breath_duty3 c=%0d: got %b want %b", c, bus.led, want); end
            end
        end
    endtask

    task automatic test_mid_events();
        logic [3:0] want;
        bus.cntl = 3'd0;
        clk_edge();
        bus.cntl = 3'd2;
        for (int c = 0; c < 10; c++) clk_edge();
        n_cmp++; if (bus.led !== 4'b0100) begin n_err++; $display("FAIL mid_pos2: got %b want 0100", bus.led); end
        bus.cntl = 3'd1;
        clk_edge();
        n_cmp++; if (bus.cur_mode !== 3'd1) begin n_err++; $display("FAIL mid_flash_mode: got %0d want 1", bus.cur_mode); end
        n_cmp++; if (bus.led !== 4'b1111) begin n_err++; $display("FAIL mid_flash_led: got %b want 1111", bus.led); end
        bus.cntl = 3'd2;
        for (int c = 0; c < 5; c++) begin
            clk_edge();
            want = (c < 4) ? 4'b0001 : 4'b0010;
            n_cmp++; if (bus.led !== want) begin n_err++; $display("FAIL mid_restart c=%0d: got %b want %b", c, bus.led, want); end
        end
        #2;
        rst_n = 1'b0;
        m_mode = 3'd0;
        m_t = 0;
        #1;
        n_cmp++; if (bus.led !== 4'b0000) begin n_err++; $display("FAIL async_led: got %b want 0000", bus.led); end
        n_cmp++; if (bus.cur_mode !== 3'd0) begin n_err++; $display("FAIL async_mode: got %0d want 0", bus.cur_mode); end
        clk_edge();
        rst_n = 1'b1;
        clk_edge();
        n_cmp++; if (bus.led !== 4'b0001) begin n_err++; $display("FAIL post_reset_led: got %b want 0001", bus.led); end
    endtask

    task automatic test_glitch();
        repeat (5) clk_edge();
        #1;
        bus.cntl = 3'd4;
        #2;
        bus.cntl = 3'd2;
        for (int c = 0; c < 8; c++) begin
            clk_edge();
            n_cmp++; if (bus.cur_mode !== 3'd2) begin n_err++; $display("FAIL glitch_mode c=%0d: got %0d want 2", c, bus.cur_mode); end
            n_cmp++; if (bus.led !== exp_led) begin n_err++; $display("FAIL glitch_led c=%0d: got %b want %b", c, bus.led, exp_led); end
        end
    endtask

    task automatic test_random();
        int len;
        for (int s = 0; s < 40; s++) begin
            bus.cntl = 3'($urandom_range(7, 0));
            len = $urandom_range(40, 1);
            for (int c = 0; c < len; c++) begin
                clk_edge();
                n_cmp++; if (bus.led !== exp_led) begin n_err++; $display("FAIL rand_led s=%0d c=%0d mode=%0d: got %b want %b", s, c, m_mode, bus.led, exp_led); end
                n_cmp++; if (bus.cur_mode !== exp_mode) begin n_err++; $display("FAIL rand_mode s=%0d c=%0d: got %0d want %0d", s, c, bus.cur_mode, exp_mode); end
                n_cmp++; if (bus.step_tick !== exp_tick) begin n_err++; $display("FAIL rand_tick s=%0d c=%0d: got %b want %b", s, c, bus.step_tick, exp_tick); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_run();
        test_bounce();
        test_flash_allon();
        test_breath();
        test_mid_events();
        test_glitch();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "time limit");
    end
endmodule

// File: doc/led_pattern_ctrl.md
Name: led_pattern_ctrl

Overview:
Parametrised LED pattern engine for N LEDs driven from a 3-bit mode select. Provides off, flash, run, bounce, breath and all-on patterns from one shared step timer and one PWM generator, so only one pattern's state is ever active. It sits between the control/command logic and the board LED pins. Every output is a function of registered state only, and a mode change restarts the selected pattern cleanly.

Parameters:
LED_NUM, 4, number of LEDs driven (>=1)
TICK_DIV, 25_000_000, sys_clk cycles per pattern step (>=2); 0.5 s at 50 MHz
PWM_BITS, 8, breath PWM resolution; PWM period = 2^PWM_BITS cycles (2..10)
BREATH_PERIODS, 100, PWM periods per breath duty step (>=1)

Ports:
sys_clk  in  1  system clock, 50 MHz, rising edge
rst_n  in  1  asynchronous active-low reset
cntl  in  3  mode select: 0 off, 1 flash, 2 run, 3 breath, 4 bounce, 5 all-on, 6/7 off
led  out  LED_NUM  LED drive, 1 = lit
cur_mode  out  3  currently applied mode (mode_r)
step_tick  out  1  one-cycle pulse at each pattern step

Behaviour:
- Reset (async assert, sync release): mode_r=0, tick_cnt=0, phase=0, pos=0, dir=up, duty=0, dir_b=up, pwm_cnt=0, breath_cnt=0. Outputs: led=0, cur_mode=0, step_tick=0.
- Mode capture: on any edge where cntl != mode_r:
  - mode_r<=cntl.
  - tick_cnt, pos, pwm_cnt, breath_cnt, duty <=0; dir, dir_b <= up; phase <= 1.
  - No pattern advance on that edge.
  - New pattern is visible on led one cycle after cntl changes. There is no combinational path from cntl to led.
- Step timer:
  - tick_cnt counts 0..TICK_DIV-1, then wraps.
  - step_tick=1 while tick_cnt==TICK_DIV-1, so the period is exactly TICK_DIV cycles.
  - The timer runs in every mode.
- Flash (1): phase toggles on each step_tick; led = phase ? all ones : 0. Starts lit.
- Run (2):
  - led = 1<<pos.
  - On step_tick: pos = (pos==LED_NUM-1) ? 0 : pos+1.
- Bounce (4):
  - led = 1<<pos.
  - On step_tick with dir up: if pos==LED_NUM-1, dir<=down and pos<=pos-1; else pos+1.
  - Down is symmetric at pos==0.
  - LED_NUM=1: pos stays 0 and led=1.
  - Endpoints are shown for exactly one step.
- Breath (3):
  - pwm_cnt increments every cycle, modulo 2^PWM_BITS.
  - All led bits = (pwm_cnt < duty). duty=0 gives fully dark; duty=MAX=2^PWM_BITS-1 gives lit except 1 cycle per period.
  - At pwm_cnt==MAX, breath_cnt advances 0..BREATH_PERIODS-1 and wraps.
  - When it wraps, duty steps by ±1 and is applied from the next PWM period (glitch-free).
  - Up at MAX: dir_b<=down and duty<=MAX-1. Down at 0: dir_b<=up and duty<=1.
  - Duty sequence: 0,1..MAX,MAX-1..0,1...
- All-on (5): led = all ones. Off (0,6,7): led = 0.
- pos, phase, duty and pwm state are held (not advanced) when their mode is not active.
- cntl changing back to the same value within one cycle is invisible. Only the sampled value matters.
- Widths: pos is clog2(LED_NUM) (minimum 1). tick_cnt is clog2(TICK_DIV). duty and pwm_cnt are PWM_BITS wide. No overflow is possible by construction.

Test Plan:
(All with LED_NUM=4, TICK_DIV=4, PWM_BITS=3, BREATH_PERIODS=2.)
1. Reset: hold rst_n=0 with cntl=2 -> led=0000, cur_mode=0, step_tick=0. Release -> cur_mode=2 after 1 edge, led=0001 the same cycle. step_tick first pulses 4 cycles later.
2. Run: cntl=2 -> led 0001,0010,0100,1000,0001, each held exactly 4 cycles. step_tick is high on the last cycle of each.
3. Bounce: cntl=4 -> led 0001,0010,0100,1000,0100,0010,0001,0010, each held 4 cycles.
4. Flash then all-on: cntl=1 -> 1111 for 4 cycles, 0000 for 4, 1111... Switch to cntl=5 mid-phase -> 1111 from the next cycle, steady.
5. Breath: cntl=3 -> duty advances every 16 cycles 0,1..7,6..0,1. While duty=3, led=1111 for pwm_cnt 0..2 and 0000 for 3..7. While duty=0, led stays 0000.
6. Mid-operation events:
   - Run at pos=2, switch cntl to 1 then back to 2 -> run restarts at 0001 with a full 4-cycle step.
   - Assert rst_n=0 between clock edges -> led=0000 and cur_mode=0 immediately, without waiting for a clock.
